// File: rtl/store_buffer_if.sv
// store_buffer_if: store, load-forward and memory write-port signals of the store buffer.
`default_nettype none

interface store_buffer_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          st_valid;
  logic          st_ready;
  logic [31:0]   st_addr;
  logic [31:0]   st_data;
  logic [31:0]   ld_addr;
  logic          ld_hit;
  logic [31:0]   ld_data;
  logic          mem_grant;
  logic          mem_we;
  logic [31:0]   mem_a;
  logic [31:0]   mem_wd;
  logic          empty;
  logic [CW-1:0] count;

  modport master (
    output st_valid, st_addr, st_data, ld_addr, mem_grant,
    input  st_ready, ld_hit, ld_data, mem_we, mem_a, mem_wd, empty, count
  );

  modport slave (
    input  st_valid, st_addr, st_data, ld_addr, mem_grant,
    output st_ready, ld_hit, ld_data, mem_we, mem_a, mem_wd, empty, count
  );
endinterface

`default_nettype wire

// File: rtl/store_buffer.sv
// store_buffer: word-granular circular store queue with write coalescing into the
// youngest entry, in-order drain to data memory and youngest-match load forwarding.
`default_nettype none

module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           reset,
  store_buffer_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [29:0]    addr_q [DEPTH];
  logic [31:0]    data_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [PW-1:0]  head_q;
  logic [PW-1:0]  tail_q;
  logic [CW-1:0]  count_q;

  logic [PW-1:0]  youngest;
  logic [29:0]    st_word;
  logic           full;
  logic           drain;
  logic           accept;
  logic           coalesce;
  logic           alloc;
  logic           fwd_hit;
  logic [31:0]    fwd_data;
  logic           unused_low_bits;

  assign st_word  = bus.st_addr[31:2];
  assign youngest = tail_q - PW'(1);
  assign full     = (count_q == FULL);
  assign drain    = (count_q != '0) && bus.mem_grant;
  assign accept   = bus.st_valid && !full;

  // A lone entry leaving this cycle cannot absorb a store; it must be re-allocated.
  assign coalesce = accept && (count_q != '0) && (addr_q[youngest] == st_word)
                    && !((count_q == CW'(1)) && drain);
  assign alloc    = accept && !coalesce;

  assign bus.st_ready = !full;
  assign bus.empty    = (count_q == '0);
  assign bus.count    = count_q;
  assign bus.mem_we   = drain;
  assign bus.mem_a    = (count_q != '0) ? {addr_q[head_q], 2'b00} : 32'h0;
  assign bus.mem_wd   = (count_q != '0) ? data_q[head_q] : 32'h0;
  assign bus.ld_hit   = fwd_hit;
  assign bus.ld_data  = fwd_data;

  assign unused_low_bits = ^{bus.st_addr[1:0], bus.ld_addr[1:0]};

  // Walk oldest to youngest so the last match wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = 32'h0;
    for (int k = 0; k < DEPTH; k++) begin
      if (valid_q[head_q + PW'(k)] && (addr_q[head_q + PW'(k)] == bus.ld_addr[31:2])) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[head_q + PW'(k)];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      if (drain) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + PW'(1);
      end
      if (alloc) begin
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + PW'(1);
      end
      case ({alloc, drain})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Payload needs no reset: it is only observed through valid_q and count_q.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (alloc) begin
        addr_q[tail_q] <= st_word;
        data_q[tail_q] <= bus.st_data;
      end else if (coalesce) begin
        data_q[youngest] <= bus.st_data;
      end
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed test-plan scenarios plus randomized traffic checked against a queue model.
`default_nettype none

module tb_store_buffer;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [29:0] a;
    logic [31:0] d;
  } ent_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  store_buffer_if #(.DEPTH(DEPTH)) sb();
  store_buffer #(.DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(sb));

  ent_t        mq[$];
  logic [31:0] wa[$];
  logic [31:0] wd[$];
  logic [31:0] xa[$];
  logic [31:0] xd[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic        last_acc = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: compare every output to the model mid-cycle, then advance the model at the edge.
  task automatic step();
    logic        hit;
    logic [31:0] ld;
    logic        drained;
    logic        coal;
    @(negedge clk);
    check("st_ready", sb.st_ready, mq.size() != DEPTH);
    check("empty", sb.empty, mq.size() == 0);
    check("count", sb.count, mq.size());
    check("cnt_max", sb.count <= DEPTH, 1);
    check("mem_we", sb.mem_we, (mq.size() != 0) && sb.mem_grant);
    check("mem_a", sb.mem_a, (mq.size() != 0) ? {mq[0].a, 2'b00} : 32'h0);
    check("mem_wd", sb.mem_wd, (mq.size() != 0) ? mq[0].d : 32'h0);
    hit = 1'b0;
    ld  = 32'h0;
    foreach (mq[i]) begin
      if (mq[i].a == sb.ld_addr[31:2]) begin
        hit = 1'b1;
        ld  = mq[i].d;
      end
    end
    check("ld_hit", sb.ld_hit, hit);
    check("ld_data", sb.ld_data, ld);
    if (sb.mem_we) begin
      wa.push_back(sb.mem_a);
      wd.push_back(sb.mem_wd);
    end
    @(posedge clk);
    if (reset) begin
      mq.delete();
      last_acc = 1'b0;
    end else begin
      drained  = (mq.size() != 0) && sb.mem_grant;
      last_acc = sb.st_valid && (mq.size() != DEPTH);
      coal     = last_acc && (mq.size() != 0) && (mq[$].a == sb.st_addr[31:2])
                 && !((mq.size() == 1) && drained);
      if (coal) mq[$].d = sb.st_data;
      if (drained) void'(mq.pop_front());
      if (last_acc && !coal) mq.push_back({sb.st_addr[31:2], sb.st_data});
    end
    #1;
  endtask

  task automatic idle(input int n);
    sb.st_valid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    int tries;
    tries = 0;
    sb.st_valid = 1'b1;
    sb.st_addr  = a;
    sb.st_data  = d;
    do begin
      step();
      tries++;
    end while (!last_acc && tries < 20);
    if (!last_acc) check("store_timeout", 0, 1);
    sb.st_valid = 1'b0;
  endtask

  task automatic check_writes(input string tag);
    check({tag, "_n"}, wa.size(), xa.size());
    for (int i = 0; i < xa.size() && i < wa.size(); i++) begin
      check({tag, "_a"}, wa[i], xa[i]);
      check({tag, "_d"}, wd[i], xd[i]);
    end
  endtask

  initial begin
    sb.st_valid  = 1'b0;
    sb.st_addr   = 32'h0;
    sb.st_data   = 32'h0;
    sb.ld_addr   = 32'h0;
    sb.mem_grant = 1'b0;
    reset        = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle(1);

    // Basic fill and drain
    store(32'h10, 32'hA);
    store(32'h14, 32'hB);
    store(32'h18, 32'hC);
    store(32'h1C, 32'hD);
    check("fill_cnt", sb.count, 4);
    check("fill_rdy", sb.st_ready, 0);
    wa.delete(); wd.delete();
    xa = '{32'h10, 32'h14, 32'h18, 32'h1C};
    xd = '{32'hA, 32'hB, 32'hC, 32'hD};
    sb.mem_grant = 1'b1;
    idle(4);
    sb.mem_grant = 1'b0;
    check_writes("fill_drain");
    check("fill_empty", sb.empty, 1);

    // Coalesce into youngest only
    store(32'h20, 32'h1);
    store(32'h20, 32'h2);
    check("coal_cnt", sb.count, 1);
    store(32'h24, 32'h4);
    store(32'h20, 32'h3);
    check("nocoal_cnt", sb.count, 3);
    wa.delete(); wd.delete();
    xa = '{32'h20, 32'h24, 32'h20};
    xd = '{32'h2, 32'h4, 32'h3};
    sb.mem_grant = 1'b1;
    idle(4);
    sb.mem_grant = 1'b0;
    check_writes("coal");

    // Forwarding priority
    store(32'h30, 32'h5);
    store(32'h34, 32'h6);
    store(32'h30, 32'h7);
    sb.ld_addr = 32'h30; #1;
    check("fwd30_hit", sb.ld_hit, 1);
    check("fwd30_data", sb.ld_data, 32'h7);
    sb.ld_addr = 32'h31; #1;
    check("fwd31_hit", sb.ld_hit, 1);
    check("fwd31_data", sb.ld_data, 32'h7);
    sb.ld_addr = 32'h38; #1;
    check("fwd38_hit", sb.ld_hit, 0);
    check("fwd38_data", sb.ld_data, 32'h0);
    sb.mem_grant = 1'b1;
    idle(4);
    sb.mem_grant = 1'b0;

    // Store at full with a drain: one stall cycle, then accepted
    store(32'h40, 32'h11);
    store(32'h44, 32'h12);
    store(32'h48, 32'h13);
    store(32'h4C, 32'h14);
    wa.delete(); wd.delete();
    sb.mem_grant = 1'b1;
    sb.st_valid  = 1'b1;
    sb.st_addr   = 32'h50;
    sb.st_data   = 32'hE;
    #1;
    check("full_stall", sb.st_ready, 0);
    step();
    check("full_noacc", last_acc, 0);
    check("full_rdy_back", sb.st_ready, 1);
    step();
    check("full_acc", last_acc, 1);
    idle(6);
    xa = '{32'h40, 32'h44, 32'h48, 32'h4C, 32'h50};
    xd = '{32'h11, 32'h12, 32'h13, 32'h14, 32'hE};
    check_writes("full");

    // Store to the draining lone entry allocates a new entry
    sb.mem_grant = 1'b0;
    store(32'h60, 32'h1);
    wa.delete(); wd.delete();
    sb.mem_grant = 1'b1;
    store(32'h60, 32'h2);
    check("one_cnt", sb.count, 1);
    idle(2);
    xa = '{32'h60, 32'h60};
    xd = '{32'h1, 32'h2};
    check_writes("one");

    // Wrap-around with toggling grant
    sb.mem_grant = 1'b0;
    wa.delete(); wd.delete(); xa.delete(); xd.delete();
    for (int i = 0; i < 10; i++) begin
      int tries;
      tries = 0;
      sb.st_valid = 1'b1;
      sb.st_addr  = 32'h100 + 32'(4 * i);
      sb.st_data  = $urandom;
      xa.push_back(sb.st_addr);
      xd.push_back(sb.st_data);
      do begin
        sb.mem_grant = ~sb.mem_grant;
        step();
        tries++;
      end while (!last_acc && tries < 20);
      if (!last_acc) check("wrap_timeout", 0, 1);
    end
    sb.mem_grant = 1'b1;
    idle(6);
    check_writes("wrap");

    // Reset mid-operation
    sb.mem_grant = 1'b0;
    store(32'h200, 32'h21);
    store(32'h204, 32'h22);
    store(32'h208, 32'h23);
    sb.st_valid  = 1'b1;
    sb.st_addr   = 32'h20C;
    sb.st_data   = 32'h24;
    sb.mem_grant = 1'b1;
    reset        = 1'b1;
    step();
    reset       = 1'b0;
    sb.st_valid = 1'b0;
    check("rst_cnt", sb.count, 0);
    check("rst_empty", sb.empty, 1);
    check("rst_we", sb.mem_we, 0);
    wa.delete(); wd.delete();
    idle(3);
    check("rst_nowrite", wa.size(), 0);

    // Randomized traffic over a small address pool
    for (int c = 0; c < 600; c++) begin
      reset        = ($urandom_range(0, 63) == 0);
      sb.st_valid  = $urandom_range(0, 1);
      sb.st_addr   = {24'h0, 3'($urandom_range(0, 7)), 2'b00, 2'($urandom)} + 32'h300;
      sb.st_data   = $urandom;
      sb.mem_grant = ($urandom_range(0, 2) != 0);
      sb.ld_addr   = {24'h0, 3'($urandom_range(0, 7)), 2'b00, 2'($urandom)} + 32'h300;
      step();
    end
    reset = 1'b0;
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

`default_nettype wire
